// File: rtl/iob_eth_rx_deframer_pkg.sv
// Shared constants, state type and CRC/MAC helpers for the Ethernet RX deframer.
package iob_eth_rx_deframer_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
    localparam int unsigned ETH_MIN_FRAME   = 18;
    localparam logic [47:0] ETH_BCAST_ADDR  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_END,
        ST_HOLD,
        ST_DISCARD
    } rx_state_e;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // The residue constant is quoted MSB-first; the LFSR register holds it bit-reversed.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        case (idx)
            3'd0:    return mac[47:40];
            3'd1:    return mac[39:32];
            3'd2:    return mac[31:24];
            3'd3:    return mac[23:16];
            3'd4:    return mac[15:8];
            default: return mac[7:0];
        endcase
    endfunction

endpackage

// File: rtl/iob_eth_rx_deframer_if.sv
// PHY receive symbol stream and RX buffer write port of the deframer.
interface iob_eth_rx_deframer_if #(
    parameter int unsigned PHY_W      = 4,
    parameter int unsigned BUF_ADDR_W = 11
);
    logic                  phy_en;
    logic                  phy_dv;
    logic [PHY_W-1:0]      phy_data;
    logic                  buf_we;
    logic [BUF_ADDR_W-1:0] buf_addr;
    logic [7:0]            buf_wdata;

    modport master (input phy_en, phy_dv, phy_data, output buf_we, buf_addr, buf_wdata);
    modport slave  (output phy_en, phy_dv, phy_data, input buf_we, buf_addr, buf_wdata);
endinterface

// File: rtl/iob_eth_rx_deframer_crc32.sv
// Byte-wise IEEE 802.3 CRC-32 (reflected, init all-ones, no final inversion applied).
module iob_eth_rx_deframer_crc32
    import iob_eth_rx_deframer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);
    logic [31:0] crc_q;

    always_ff @(posedge clk) begin
        if (rst || init_i) begin
            crc_q <= '1;
        end else if (en_i) begin
            crc_q <= crc32_byte(crc_q, data_i);
        end
    end

    assign crc_o = crc_q;
endmodule

// File: rtl/iob_eth_rx_deframer.sv
// MII/GMII receive deframer: preamble hunt, byte assembly, dest-MAC filter, CRC check, frame hold.
module iob_eth_rx_deframer
    import iob_eth_rx_deframer_pkg::*;
#(
    parameter int unsigned PHY_W      = 4,
    parameter int unsigned BUF_ADDR_W = 11,
    parameter int unsigned MAC_FILTER = 1,
    parameter int unsigned DROP_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    iob_eth_rx_deframer_if.master  bus,
    input  logic [47:0]            mac_addr_i,
    input  logic                   promisc_i,
    input  logic                   rcv_ack_i,
    output logic                   rx_ready_o,
    output logic [BUF_ADDR_W:0]    rx_nbytes_o,
    output logic                   rx_crc_err_o,
    output logic [DROP_W-1:0]      drop_cnt_o
);
    localparam int unsigned       CNT_W    = BUF_ADDR_W + 1;
    localparam logic [PHY_W-1:0]  SYM_PRE  = ETH_PREAMBLE[PHY_W-1:0];
    localparam logic [PHY_W-1:0]  SYM_SFD  = ETH_SFD[7 -: PHY_W];
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(1) << BUF_ADDR_W;
    localparam logic [CNT_W-1:0]  CNT_MIN  = CNT_W'(ETH_MIN_FRAME);
    localparam logic [CNT_W-1:0]  FCS_LEN  = CNT_W'(4);

    rx_state_e             state_q;
    logic [CNT_W-1:0]      byte_cnt_q;
    logic                  dv_q, da_match_q, da_bcast_q;
    logic                  buf_we_q;
    logic [BUF_ADDR_W-1:0] buf_addr_q;
    logic [7:0]            buf_wdata_q;
    logic                  rx_ready_q, rx_crc_err_q;
    logic [CNT_W-1:0]      rx_nbytes_q;
    logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic                  sym_done, da_match_d, da_bcast_d, da_pass;
    logic [7:0]            sym_byte;
    logic [31:0]           crc;

    generate
        if (PHY_W == 4) begin : g_mii
            logic       half_q;
            logic [3:0] nib_q;
            always_ff @(posedge clk) begin
                if (rst || state_q != ST_DATA) begin
                    half_q <= 1'b0;
                    nib_q  <= '0;
                end else if (bus.phy_en && bus.phy_dv) begin
                    half_q <= !half_q;
                    nib_q  <= bus.phy_data;
                end
            end
            assign sym_done = half_q;
            assign sym_byte = {bus.phy_data, nib_q};
        end else begin : g_gmii
            assign sym_done = 1'b1;
            assign sym_byte = bus.phy_data;
        end
    endgenerate

    assign drop_cnt_d = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + 1'b1;
    assign da_match_d = da_match_q && (sym_byte == mac_byte(mac_addr_i, byte_cnt_q[2:0]));
    assign da_bcast_d = da_bcast_q && (sym_byte == mac_byte(ETH_BCAST_ADDR, byte_cnt_q[2:0]));
    assign da_pass    = (MAC_FILTER == 0) || promisc_i || da_match_d || da_bcast_d;

    iob_eth_rx_deframer_crc32 u_crc (
        .clk    (clk),
        .rst    (rst),
        .init_i (state_q == ST_IDLE),
        .en_i   (buf_we_q),
        .data_i (buf_wdata_q),
        .crc_o  (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            dv_q         <= 1'b0;
            da_match_q   <= 1'b1;
            da_bcast_q   <= 1'b1;
            buf_we_q     <= 1'b0;
            buf_addr_q   <= '0;
            buf_wdata_q  <= '0;
            rx_ready_q   <= 1'b0;
            rx_nbytes_q  <= '0;
            rx_crc_err_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            buf_we_q <= 1'b0;
            if (bus.phy_en) dv_q <= bus.phy_dv;
            case (state_q)
                ST_IDLE: begin
                    byte_cnt_q <= '0;
                    da_match_q <= 1'b1;
                    da_bcast_q <= 1'b1;
                    if (bus.phy_en && bus.phy_dv)
                        state_q <= (bus.phy_data == SYM_PRE) ? ST_PREAMBLE : ST_DISCARD;
                end
                ST_PREAMBLE: if (bus.phy_en) begin
                    if (!bus.phy_dv)                  state_q <= ST_IDLE;
                    else if (bus.phy_data == SYM_SFD) state_q <= ST_DATA;
                    else if (bus.phy_data != SYM_PRE) state_q <= ST_DISCARD;
                end
                ST_DATA: if (bus.phy_en) begin
                    if (!bus.phy_dv) begin
                        state_q <= ST_END;
                    end else if (sym_done) begin
                        if (byte_cnt_q == CNT_FULL) begin
                            state_q    <= ST_DISCARD;
                            drop_cnt_q <= drop_cnt_d;
                        end else begin
                            buf_we_q    <= 1'b1;
                            buf_addr_q  <= byte_cnt_q[BUF_ADDR_W-1:0];
                            buf_wdata_q <= sym_byte;
                            byte_cnt_q  <= byte_cnt_q + 1'b1;
                            da_match_q  <= da_match_d;
                            da_bcast_q  <= da_bcast_d;
                            if (byte_cnt_q == CNT_W'(5) && !da_pass) state_q <= ST_DISCARD;
                        end
                    end
                end
                // CRC has absorbed the last byte by now: it lands one clk after its strobe.
                ST_END: begin
                    if (byte_cnt_q < CNT_MIN) begin
                        state_q    <= ST_IDLE;
                        drop_cnt_q <= drop_cnt_d;
                    end else begin
                        state_q      <= ST_HOLD;
                        rx_ready_q   <= 1'b1;
                        rx_nbytes_q  <= byte_cnt_q - FCS_LEN;
                        rx_crc_err_q <= (reflect32(crc) != ETH_CRC_RESIDUE);
                    end
                end
                ST_HOLD: begin
                    if (bus.phy_en && bus.phy_dv && !dv_q) drop_cnt_q <= drop_cnt_d;
                    if (rcv_ack_i) begin
                        rx_ready_q <= 1'b0;
                        state_q    <= bus.phy_dv ? ST_DISCARD : ST_IDLE;
                    end
                end
                ST_DISCARD: if (bus.phy_en && !bus.phy_dv) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.buf_we    = buf_we_q;
    assign bus.buf_addr  = buf_addr_q;
    assign bus.buf_wdata = buf_wdata_q;
    assign rx_ready_o    = rx_ready_q;
    assign rx_nbytes_o   = rx_nbytes_q;
    assign rx_crc_err_o  = rx_crc_err_q;
    assign drop_cnt_o    = drop_cnt_q;
endmodule

// File: tb/tb_iob_eth_rx_deframer.sv
// Bench for the RX deframer: an MII instance and a GMII instance with a small buffer and narrow drop counter.
module tb_iob_eth_rx_deframer;
    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, promisc, ack_a, ack_b;
    logic [47:0] mac;
    logic        rdy_a, err_a, rdy_b, err_b;
    logic [11:0] nb_a;
    logic [6:0]  nb_b;
    logic [15:0] drop_a;
    logic [1:0]  drop_b;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [7:0]  mem_a [2048];
    logic [7:0]  mem_b [64];
    bit          held [2];
    bit          exp_err [2];
    logic [31:0] exp_drop [2];
    logic [31:0] exp_nb [2];
    bq_t         hq0, hq1;

    iob_eth_rx_deframer_if #(.PHY_W(4), .BUF_ADDR_W(11)) ifa ();
    iob_eth_rx_deframer_if #(.PHY_W(8), .BUF_ADDR_W(6))  ifb ();

    iob_eth_rx_deframer #(.PHY_W(4), .BUF_ADDR_W(11), .MAC_FILTER(1), .DROP_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.master), .mac_addr_i(mac), .promisc_i(promisc),
        .rcv_ack_i(ack_a), .rx_ready_o(rdy_a), .rx_nbytes_o(nb_a), .rx_crc_err_o(err_a), .drop_cnt_o(drop_a));

    iob_eth_rx_deframer #(.PHY_W(8), .BUF_ADDR_W(6), .MAC_FILTER(1), .DROP_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.master), .mac_addr_i(mac), .promisc_i(promisc),
        .rcv_ack_i(ack_b), .rx_ready_o(rdy_b), .rx_nbytes_o(nb_b), .rx_crc_err_o(err_b), .drop_cnt_o(drop_b));

    always @(posedge clk) begin
        if (ifa.buf_we) mem_a[ifa.buf_addr] <= ifa.buf_wdata;
        if (ifb.buf_we) mem_b[ifb.buf_addr] <= ifb.buf_wdata;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Standard Ethernet FCS: bit-serial reflected CRC-32, final inversion.
    function automatic logic [31:0] fcs_of(input bq_t q, input int unsigned len);
        logic [31:0] c;
        logic        fb;
        c = '1;
        for (int unsigned i = 0; i < len; i++) begin
            for (int unsigned b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    function automatic bq_t make_frame(input logic [47:0] dest, input int unsigned plen, input bit flip);
        bq_t         q;
        logic [31:0] f;
        int unsigned pos;
        for (int unsigned k = 0; k < 6; k++) q.push_back(dest[47-8*k -: 8]);
        for (int unsigned k = 0; k < 6; k++) q.push_back(8'($urandom));
        q.push_back(8'h08);
        q.push_back(8'h00);
        for (int unsigned k = 0; k < plen; k++) q.push_back(8'($urandom));
        f = fcs_of(q, q.size());
        for (int unsigned k = 0; k < 4; k++) q.push_back(f[8*k +: 8]);
        if (flip) begin
            pos = 14 + $urandom_range(0, plen - 1);
            q[pos] = q[pos] ^ (8'h01 << $urandom_range(0, 7));
        end
        return q;
    endfunction

    task automatic put_sym(input int unsigned w, input logic dv, input logic [7:0] d, input int unsigned div);
        if (w == 0) begin
            ifa.phy_en = 1'b1; ifa.phy_dv = dv; ifa.phy_data = d[3:0];
        end else begin
            ifb.phy_en = 1'b1; ifb.phy_dv = dv; ifb.phy_data = d;
        end
        @(posedge clk); #1;
        ifa.phy_en = 1'b0;
        ifb.phy_en = 1'b0;
        for (int unsigned k = 1; k < div; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic put_byte(input int unsigned w, input logic [7:0] b, input int unsigned div);
        if (w == 0) begin
            put_sym(0, 1'b1, {4'h0, b[3:0]}, div);
            put_sym(0, 1'b1, {4'h0, b[7:4]}, div);
        end else begin
            put_sym(1, 1'b1, b, div);
        end
    endtask

    task automatic send_frame(input int unsigned w, input bq_t q, input int unsigned div,
                              input int unsigned cut, input bit dribble);
        repeat (7) put_byte(w, 8'h55, div);
        put_byte(w, 8'hD5, div);
        for (int unsigned i = 0; i < cut; i++) put_byte(w, q[i], div);
        if (cut < q.size()) return;
        if (dribble) put_sym(w, 1'b1, 8'($urandom), div);
        repeat (12) put_sym(w, 1'b0, 8'h00, div);
    endtask

    task automatic get_out(input int unsigned w, output logic [31:0] r, output logic [31:0] nb,
                           output logic [31:0] e, output logic [31:0] d, output logic [31:0] we);
        if (w == 0) begin
            r = 32'(rdy_a); nb = 32'(nb_a); e = 32'(err_a); d = 32'(drop_a); we = 32'(ifa.buf_we);
        end else begin
            r = 32'(rdy_b); nb = 32'(nb_b); e = 32'(err_b); d = 32'(drop_b); we = 32'(ifb.buf_we);
        end
    endtask

    function automatic int unsigned bad_bytes(input int unsigned w);
        int unsigned bad = 0;
        bq_t         q;
        logic [7:0]  m;
        q = (w == 0) ? hq0 : hq1;
        for (int unsigned i = 0; i < q.size(); i++) begin
            m = (w == 0) ? mem_a[11'(i)] : mem_b[6'(i)];
            if (m !== q[i]) bad++;
        end
        return bad;
    endfunction

    task automatic bump(input int unsigned w);
        logic [31:0] lim;
        lim = (w == 0) ? 32'hFFFF : 32'h3;
        if (exp_drop[w] < lim) exp_drop[w]++;
    endtask

    // Predicts the frame's fate from the receive rules, sends it, then checks the outcome.
    task automatic run_frame(input int unsigned w, input bq_t q, input int unsigned div, input bit dribble);
        logic [47:0] da;
        logic [31:0] r, nb, e, d, we;
        bit          pass;
        int unsigned n, cap;
        n   = q.size();
        cap = (w == 0) ? 2048 : 64;
        da  = {q[0], q[1], q[2], q[3], q[4], q[5]};
        pass = promisc || (da == mac) || (da == 48'hFFFF_FFFF_FFFF);
        if (!held[w]) begin
            for (int unsigned i = 0; i < 2048; i++) mem_a[i] = (w == 0) ? 8'hxx : mem_a[i];
            for (int unsigned i = 0; i < 64; i++)   mem_b[i] = (w == 1) ? 8'hxx : mem_b[i];
        end
        if (held[w]) bump(w);
        else if (pass) begin
            if (n > cap || n < 18) bump(w);
            else begin
                held[w]    = 1'b1;
                exp_nb[w]  = n - 4;
                exp_err[w] = (fcs_of(q, n - 4) != {q[n-1], q[n-2], q[n-3], q[n-4]});
                if (w == 0) hq0 = q; else hq1 = q;
            end
        end
        send_frame(w, q, div, n, dribble);
        get_out(w, r, nb, e, d, we);
        chk("rx_ready", r, 32'(held[w]));
        chk("drop_cnt", d, exp_drop[w]);
        if (held[w]) begin
            chk("rx_nbytes", nb, exp_nb[w]);
            chk("rx_crc_err", e, 32'(exp_err[w]));
            chk("buffer_bad_bytes", bad_bytes(w), 32'd0);
        end
    endtask

    task automatic ack(input int unsigned w);
        logic [31:0] r, nb, e, d, we;
        if (w == 0) ack_a = 1'b1; else ack_b = 1'b1;
        @(posedge clk); #1;
        ack_a = 1'b0;
        ack_b = 1'b0;
        held[w] = 1'b0;
        get_out(w, r, nb, e, d, we);
        chk("rx_ready_after_ack", r, 32'd0);
    endtask

    initial begin
        logic [31:0] r, nb, e, d, we;
        logic [47:0] other, bcast, dest;
        bq_t         q;
        rst = 1'b1; promisc = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
        mac = {16'h0212, 32'($urandom)};
        other = 48'h02_00_00_00_00_01;
        bcast = 48'hFFFF_FFFF_FFFF;
        ifa.phy_en = 1'b0; ifa.phy_dv = 1'b0; ifa.phy_data = '0;
        ifb.phy_en = 1'b0; ifb.phy_dv = 1'b0; ifb.phy_data = '0;
        held[0] = 1'b0; held[1] = 1'b0;
        exp_drop[0] = 0; exp_drop[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int unsigned w = 0; w < 2; w++) begin
            get_out(w, r, nb, e, d, we);
            chk("reset_rx_ready", r, 32'd0);
            chk("reset_rx_nbytes", nb, 32'd0);
            chk("reset_rx_crc_err", e, 32'd0);
            chk("reset_drop_cnt", d, 32'd0);
            chk("reset_buf_we", we, 32'd0);
        end
        rst = 1'b0;

        // MII: good frame, corrupted frame, address filtering, dribble nibble
        run_frame(0, make_frame(mac, 46, 1'b0), 1, 1'b0);
        chk("mii_nbytes_60", 32'(nb_a), 32'd60);
        ack(0);
        run_frame(0, make_frame(mac, 46, 1'b1), 1, 1'b0);
        ack(0);
        run_frame(0, make_frame(other, 46, 1'b0), 1, 1'b0);
        promisc = 1'b1;
        run_frame(0, make_frame(other, 50, 1'b0), 1, 1'b1);
        ack(0);
        promisc = 1'b0;
        run_frame(0, make_frame(bcast, 46, 1'b0), 1, 1'b0);
        ack(0);

        // Back-to-back frames while one is held, then normal reception again
        run_frame(0, make_frame(mac, 46, 1'b0), 1, 1'b0);
        run_frame(0, make_frame(mac, 46, 1'b0), 1, 1'b0);
        ack(0);
        run_frame(0, make_frame(mac, 70, 1'b0), 1, 1'b0);
        ack(0);

        for (int k = 0; k < 5; k++) begin
            case ($urandom_range(0, 2))
                0:       dest = mac;
                1:       dest = bcast;
                default: dest = other;
            endcase
            promisc = 1'($urandom_range(0, 1));
            run_frame(0, make_frame(dest, $urandom_range(30, 120), 1'($urandom_range(0, 1))), 1,
                      1'($urandom_range(0, 1)));
            if (held[0]) ack(0);
        end
        promisc = 1'b0;

        // GMII, strobe every 2nd clk: exactly-full 64-byte frame, overflow, runts, saturation
        run_frame(1, make_frame(mac, 46, 1'b0), 2, 1'b0);
        ack(1);
        run_frame(1, make_frame(mac, 62, 1'b0), 1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            q = {};
            for (int unsigned i = 0; i < 6; i++) q.push_back(mac[47-8*i -: 8]);
            for (int unsigned i = 0; i < 4; i++) q.push_back(8'($urandom));
            run_frame(1, q, 1, 1'b0);
        end

        // Reset in the middle of a frame, then a clean frame
        send_frame(1, make_frame(mac, 46, 1'b0), 2, 20, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        get_out(1, r, nb, e, d, we);
        chk("midrst_rx_ready", r, 32'd0);
        chk("midrst_rx_nbytes", nb, 32'd0);
        chk("midrst_drop_cnt", d, 32'd0);
        chk("midrst_buf_we", we, 32'd0);
        rst = 1'b0;
        ifb.phy_dv = 1'b0;
        exp_drop[1] = 0;
        held[1] = 1'b0;
        repeat (4) put_sym(1, 1'b0, 8'h00, 2);
        run_frame(1, make_frame(mac, 46, 1'b0), 2, 1'b0);
        ack(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
